ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, the successor to the single-byte decoder. It oversamples the PS/2 clock and data lines in the system clock domain and validates the start, odd-parity and stop bits. Good bytes are buffered in a configurable first-word-fall-through (FWFT) FIFO, with a selectable interrupt mode and sticky error and overflow flags. It sits between the keyboard pins and the host-side reader (CPU bus or UART bridge).

Parameters:
SYNC_STAGES, 2, synchroniser flops on ps2_clk_i/ps2_data_i (min 2)
FIFO_DEPTH, 8, FIFO entries; power of two, 2..64
TIMEOUT_CYCLES, 4000, clk cycles without a ps2_clk falling edge mid-frame before abort
INT_MODE, 0, 0 = sticky event interrupt, 1 = level interrupt (int_o = rd_valid)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ps2_clk_i  in  1  raw PS/2 clock (async)
ps2_data_i  in  1  raw PS/2 data (async)
rd_en  in  1  pop head byte; ignored when empty
clear_int  in  1  clears int_o (mode 0), overflow, frame_err
rd_data  out  8  FIFO head; valid when rd_valid
rd_valid  out  1  FIFO not empty
fifo_full  out  1  level == FIFO_DEPTH
level  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: good byte dropped because FIFO full
frame_err  out  1  sticky: bad start/parity/stop or timeout
int_o  out  1  interrupt to host

Behaviour:
- Reset (rst=1 at clk edge): FSM IDLE, FIFO emptied, bit/timeout counters 0, synchronisers loaded with 1. All outputs 0; rd_data = 0.
- Edge detect: fall = sync_q & ~sync_now on the synchronised ps2_clk. Data is sampled from synchronised ps2_data on the cycle fall=1.
- FSM (advances only on fall):
  - IDLE: sampled 0 goes to DATA with bitcnt=0. A sampled 1 is ignored (noise); no error.
  - DATA: shift right (LSB first). After the 8th bit go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: return to IDLE. If stop==1 and ^{data,parity}==1 (odd), push. Otherwise set frame_err and discard.
- Timeout: in any non-IDLE state, the counter increments each clk and resets on fall. At TIMEOUT_CYCLES it goes to IDLE and sets frame_err; the partial byte is discarded.
- Latency: raw falling edge of the stop bit to rd_valid=1 is exactly SYNC_STAGES+2 clk cycles.
- FIFO is FWFT. rd_data reflects the head combinationally from registered storage. rd_en pops on the clock edge.
- Push while full without rd_en: byte dropped, overflow<=1, contents unchanged.
- Push while full with rd_en in the same cycle: both occur; level stays at FIFO_DEPTH; no overflow.
- Push and pop at level 0: the push is accepted and the pop is ignored (rd_valid was 0).
- Pointers wrap modulo FIFO_DEPTH. level is never read as 0 when full (extra bit).
- INT_MODE 0: int_o<=1 on every accepted push. clear_int clears it; a push in the same cycle as clear_int wins (int_o stays 1).
- INT_MODE 1: int_o = rd_valid; clear_int does not affect int_o.
- overflow and frame_err clear only on clear_int or rst. A set event in the same cycle as clear_int wins.
- rst mid-frame: the frame is aborted with no error. The keyboard's remaining edges are treated as IDLE noise until the next start bit.

Decomposition:
- ps2_pkg: state enum (IDLE, DATA, PARITY, STOP), FRAME_DATA_BITS=8, and an odd-parity function.
- Sub-module sync_fifo (params WIDTH, DEPTH) holds storage, pointers, level, full and empty.
- ps2_rx_fifo contains the synchroniser, edge detect, FSM, timeout, flags and interrupt.

Test Plan:
- Send 0x1C with parity 0 and good stop -> rd_data=0x1C, rd_valid=1 exactly SYNC_STAGES+2 clks after the stop edge; int_o=1; frame_err=0.
- Send 0xF0 with parity 0 (wrong, even) -> FIFO stays empty, frame_err=1. clear_int -> frame_err=0.
- Send 9 good bytes 0x01..0x09 without reading (DEPTH=8) -> fifo_full=1, level=8, overflow=1. Popping 8 times yields 0x01..0x08.
- Full FIFO, pop asserted in the same cycle a 0x55 push lands -> level stays 8, overflow=0, last entry is 0x55.
- Stop toggling ps2_clk after 4 data bits -> frame_err=1 exactly TIMEOUT_CYCLES clks after the last edge. The next full frame 0x2A is received correctly.
- INT_MODE=1: one byte received -> int_o=1; clear_int keeps int_o=1; rd_en drops int_o=0. Also rst asserted mid-frame -> all outputs 0 and no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame FSM states, frame geometry and the parity check.
package ps2_pkg;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned BITCNT_W        = $clog2(FRAME_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // True when data plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                         input logic                       par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with an extra level bit so full never reads as empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A pop frees the slot the simultaneous push lands in; a pop on empty is ignored.
  assign do_wr = wr_en & (~full | rd_en);
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      level <= level + (AW+1)'(1);
      else if (!do_wr && do_rd) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, frame FSM with timeout, buffered
// in a FWFT FIFO with sticky error/overflow flags and a selectable interrupt.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter int unsigned INT_MODE       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  input  logic                          rd_en,
  input  logic                          clear_int,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          int_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0]     clk_sync;
  logic [SYNC_STAGES-1:0]     dat_sync;
  logic                       sync_q;
  logic                       fall_q;
  logic                       data_q;
  ps2_state_e                 state_q;
  ps2_state_e                 next_state;
  logic [BITCNT_W-1:0]        bitcnt;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       par_q;
  logic [TO_W-1:0]            to_cnt;
  logic                       push_c;
  logic                       bad_c;
  logic                       timeout_c;
  logic                       accept_c;
  logic                       drop_c;
  logic                       fifo_empty;
  logic                       int_q;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      sync_q   <= 1'b1;
      fall_q   <= 1'b0;
      data_q   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data_i};
      sync_q   <= clk_sync[SYNC_STAGES-1];
      fall_q   <= sync_q & ~clk_sync[SYNC_STAGES-1];
      data_q   <= dat_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // Timeout has priority only when no edge arrives in the same cycle.
  always_comb begin
    next_state = state_q;
    push_c     = 1'b0;
    bad_c      = 1'b0;
    timeout_c  = 1'b0;
    if (state_q != IDLE && !fall_q && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      next_state = IDLE;
      timeout_c  = 1'b1;
    end else if (fall_q) begin
      case (state_q)
        IDLE:   if (!data_q) next_state = DATA;
        DATA:   if (bitcnt == BITCNT_W'(FRAME_DATA_BITS - 1)) next_state = PARITY;
        PARITY: next_state = STOP;
        STOP: begin
          next_state = IDLE;
          if (data_q && odd_parity_ok(shreg, par_q)) push_c = 1'b1;
          else                                      bad_c  = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      shreg  <= '0;
      par_q  <= 1'b0;
      to_cnt <= '0;
    end else begin
      if (state_q == IDLE || fall_q) to_cnt <= '0;
      else                           to_cnt <= to_cnt + TO_W'(1);
      if (fall_q) begin
        case (state_q)
          IDLE:    bitcnt <= '0;
          DATA: begin
            shreg  <= {data_q, shreg[FRAME_DATA_BITS-1:1]};
            bitcnt <= bitcnt + BITCNT_W'(1);
          end
          PARITY:  par_q <= data_q;
          default: ;
        endcase
      end
    end
  end

  assign accept_c = push_c & (~fifo_full | rd_en);
  assign drop_c   = push_c & fifo_full & ~rd_en;

  sync_fifo #(
    .WIDTH (FRAME_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_c),
    .wr_data (shreg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd_valid = ~fifo_empty;

  // Sticky flags: a set event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      if (drop_c)                overflow <= 1'b1;
      else if (clear_int)        overflow <= 1'b0;
      if (bad_c || timeout_c)    frame_err <= 1'b1;
      else if (clear_int)        frame_err <= 1'b0;
      if (accept_c)              int_q <= 1'b1;
      else if (clear_int)        int_q <= 1'b0;
    end
  end

  assign int_o = (INT_MODE != 0) ? rd_valid : int_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: an event-interrupt instance scoreboarded through a byte
// queue, and a level-interrupt instance sharing the same PS/2 lines.
module tb_ps2_rx_fifo;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 200;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  logic rst0 = 1'b1, rd_en0 = 1'b0, clr0 = 1'b0;
  logic rst1 = 1'b1, rd_en1 = 1'b0, clr1 = 1'b0;
  logic [7:0]    rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, full0, full1;
  logic [LW-1:0] level0, level1;
  logic          ovf0, ovf1, ferr0, ferr1, int0, int1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .INT_MODE(0)) dut0 (
    .clk(clk), .rst(rst0), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_dat),
    .rd_en(rd_en0), .clear_int(clr0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .fifo_full(full0), .level(level0), .overflow(ovf0), .frame_err(ferr0), .int_o(int0)
  );

  ps2_rx_fifo #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .INT_MODE(1)) dut1 (
    .clk(clk), .rst(rst1), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_dat),
    .rd_en(rd_en1), .clear_int(clr1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .fifo_full(full1), .level(level1), .overflow(ovf1), .frame_err(ferr1), .int_o(int1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic good);
    return {1'b1, good ? ~^b : ^b, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  // Drive a bit and its falling edge only; the edge lands on a negedge of clk.
  task automatic fall_only(input logic v);
    ps2_dat = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic rise_after_fall();
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b1), 11);
    if (q0.size() < DEPTH) q0.push_back(b);
  endtask

  // Count posedges after a raw falling edge until the selected flag rises (-1 on expiry).
  task automatic measure(input int sel, input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if ((sel == 0) ? rd_valid0 : ferr0) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic read0(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    check_eq({tag, " valid"}, 32'(rd_valid0), 32'd1);
    exp = (q0.size() > 0) ? q0.pop_front() : 8'hXX;
    check_eq(tag, 32'(rd_data0), 32'(exp));
    rd_en0 = 1'b1;
    @(negedge clk);
    rd_en0 = 1'b0;
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) clr0 = 1'b1; else clr1 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    clr1 = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [10:0] f;

    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    check_eq("rst rd_data", 32'(rd_data0), 32'd0);
    check_eq("rst rd_valid", 32'(rd_valid0), 32'd0);
    check_eq("rst level", 32'(level0), 32'd0);
    check_eq("rst flags", 32'({full0, ovf0, ferr0, int0}), 32'd0);

    // Good byte with latency measured from the raw stop-bit edge.
    f = mk_frame(8'h1C, 1'b1);
    send_bits(f, 10);
    fall_only(f[10]);
    measure(0, 20, cnt);
    check_eq("push latency", 32'(cnt), 32'(SYNC + 2));
    q0.push_back(8'h1C);
    check_eq("int after push", 32'(int0), 32'd1);
    check_eq("no ferr", 32'(ferr0), 32'd0);
    rise_after_fall();
    read0("rd 1C");
    pulse(0);
    check_eq("int cleared", 32'(int0), 32'd0);

    // Wrong parity is discarded and flagged.
    send_bits(mk_frame(8'hF0, 1'b0), 11);
    check_eq("bad par empty", 32'(rd_valid0), 32'd0);
    check_eq("bad par ferr", 32'(ferr0), 32'd1);
    pulse(0);
    check_eq("ferr cleared", 32'(ferr0), 32'd0);

    // Nine bytes into an eight-deep FIFO.
    for (int b = 1; b <= 9; b++) send_byte(8'(b));
    check_eq("full", 32'(full0), 32'd1);
    check_eq("level full", 32'(level0), 32'(DEPTH));
    check_eq("overflow", 32'(ovf0), 32'd1);
    pulse(0);
    check_eq("ovf cleared", 32'(ovf0), 32'd0);

    // Pop coincides with the cycle the 0x55 push lands.
    f = mk_frame(8'h55, 1'b1);
    send_bits(f, 10);
    fall_only(f[10]);
    repeat (3) @(negedge clk);
    check_eq("head before pop", 32'(rd_data0), 32'(q0[0]));
    rd_en0 = 1'b1;
    @(negedge clk);
    rd_en0 = 1'b0;
    void'(q0.pop_front());
    q0.push_back(8'h55);
    check_eq("level stays", 32'(level0), 32'(DEPTH));
    check_eq("no overflow", 32'(ovf0), 32'd0);
    rise_after_fall();
    while (q0.size() > 0) read0("drain");
    check_eq("drained", 32'(rd_valid0), 32'd0);

    // Timeout: clock stops after four data bits; counted from when the edge takes effect.
    f = mk_frame(8'hA5, 1'b1);
    send_bits(f, 4);
    fall_only(f[4]);
    measure(1, TMO + 50, cnt);
    check_eq("timeout cycles", 32'(cnt - (SYNC + 2)), 32'(TMO));
    check_eq("timeout empty", 32'(rd_valid0), 32'd0);
    rise_after_fall();
    pulse(0);
    send_byte(8'h2A);
    read0("rd 2A");
    check_eq("2A no ferr", 32'(ferr0), 32'd0);

    // Level-interrupt instance.
    @(negedge clk);
    rst1 = 1'b0;
    send_byte(8'h3B);
    check_eq("m1 int", 32'(int1), 32'd1);
    check_eq("m1 data", 32'(rd_data1), 32'h3B);
    pulse(1);
    check_eq("m1 int kept", 32'(int1), 32'd1);
    @(negedge clk);
    rd_en1 = 1'b1;
    @(negedge clk);
    rd_en1 = 1'b0;
    check_eq("m1 int drop", 32'(int1), 32'd0);
    send_byte(8'h77);
    check_eq("m1 valid", 32'(rd_valid1), 32'd1);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h66, 1'b1), 4);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    check_eq("m1 rst outs", 32'({rd_data1, rd_valid1, full1, level1, ovf1, ferr1, int1}), 32'd0);
    repeat (TMO + 20) @(negedge clk);
    check_eq("m1 rst no ferr", 32'(ferr1), 32'd0);
    send_byte(8'h4D);
    check_eq("m1 recover", 32'(rd_data1), 32'h4D);
    check_eq("m1 recover ferr", 32'(ferr1), 32'd0);

    while (q0.size() > 0) read0("final drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
